nand_resp_checker: RTL and testbench

Response-checking end of the NAND gate test flow. Samples the stimulus pair (a, b) and the gate output y every cycle. Once the inputs have settled, it compares y against ~(a & b). It accumulates check, error and input-coverage results into a pass/fail verdict that a test controller or synthesizable self-test wrapper can read.

---
 rtl/nand_resp_checker.sv | 160 ++++++++++++++++
 tb/tb_nand_resp_checker.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_resp_checker.sv
// nand_resp_checker: response checker for a NAND gate test flow.
// Samples the stimulus pair {a,b} and the gate output y every cycle. Once a
// pair has been stable long enough, y is checked once against ~(a & b), and
// check, error and input-coverage results are gathered into a pass/fail verdict.
//
// Ports:
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   start, stop    open a session (clears results) / close it and publish the verdict
//   a, b, y        gate inputs as driven to the gate, and the gate output under test
//   busy, done     high while a session runs / while the verdict is published
//   pass           verdict, valid while done=1
//   chk_cnt        checks performed (saturating)
//   err_cnt        mismatches seen (saturating)
//   cov            bit {a,b} set once that input combination has been checked
//   first_err_vec  {a,b,y} captured at the first mismatch
//   err_pulse      one-cycle pulse per mismatch
module nand_resp_checker #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] chk_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       cov,
    output logic [2:0]       first_err_vec,
    output logic             err_pulse
);

    localparam int unsigned STAB_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [1:0]        r_prev;
    logic [STAB_W-1:0] r_stab;
    logic [CNT_W-1:0]  r_chk;
    logic [CNT_W-1:0]  r_err;
    logic [3:0]        r_cov;
    logic [2:0]        r_fev;
    logic              r_pass;
    logic              r_busy;
    logic              r_done;
    logic              r_err_pulse;

    logic [1:0]        w_pair;
    logic              w_enter;
    logic              w_check;
    logic              w_exp_y;
    logic              w_mis;
    logic [CNT_W-1:0]  w_chk_nxt;
    logic [CNT_W-1:0]  w_err_nxt;
    logic [3:0]        w_cov_nxt;
    logic [2:0]        w_fev_nxt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is ignored in RUN, stop is ignored outside RUN
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (stop)  w_next = S_DONE;
            S_DONE:  if (start) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    // Check qualification and next values of the result registers
    always_comb begin
        w_pair    = {a, b};
        w_enter   = (r_state != S_RUN) && (w_next == S_RUN);
        w_check   = (r_state == S_RUN) && (w_pair == r_prev) &&
                    (r_stab == STAB_W'(SETTLE - 1));
        w_exp_y   = ~(a & b);
        // Case-inequality so an X/Z on y is reported as a mismatch in simulation
        w_mis     = w_check && (y !== w_exp_y);
        w_chk_nxt = (w_check && (r_chk != CNT_MAX)) ? r_chk + CNT_W'(1) : r_chk;
        w_err_nxt = (w_mis && (r_err != CNT_MAX)) ? r_err + CNT_W'(1) : r_err;
        w_cov_nxt = w_check ? (r_cov | (4'(1) << w_pair)) : r_cov;
        w_fev_nxt = (w_mis && (r_err == '0)) ? {a, b, y} : r_fev;
    end

    // Result, settle-tracking and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev      <= 2'b00;
            r_stab      <= '0;
            r_chk       <= '0;
            r_err       <= '0;
            r_cov       <= 4'h0;
            r_fev       <= 3'b000;
            r_pass      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            r_busy      <= (w_next == S_RUN);
            r_done      <= (w_next == S_DONE);
            r_err_pulse <= w_mis;
            if (w_enter) begin
                r_prev <= w_pair;
                r_stab <= '0;
                r_chk  <= '0;
                r_err  <= '0;
                r_cov  <= 4'h0;
                r_fev  <= 3'b000;
                r_pass <= 1'b0;
            end else if (r_state == S_RUN) begin
                if (w_pair != r_prev) begin
                    r_prev <= w_pair;
                    r_stab <= '0;
                end else if (r_stab < STAB_W'(SETTLE)) begin
                    r_stab <= r_stab + STAB_W'(1);
                end
                r_chk <= w_chk_nxt;
                r_err <= w_err_nxt;
                r_cov <= w_cov_nxt;
                r_fev <= w_fev_nxt;
                // Verdict uses the next values so a check in the stop cycle counts
                if (w_next == S_DONE) begin
                    r_pass <= (w_err_nxt == '0) && (w_cov_nxt == 4'hF) &&
                              (w_chk_nxt != '0);
                end
            end
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign chk_cnt       = r_chk;
    assign err_cnt       = r_err;
    assign cov           = r_cov;
    assign first_err_vec = r_fev;
    assign err_pulse     = r_err_pulse;

endmodule

// File: tb/tb_nand_resp_checker.sv
// tb_nand_resp_checker: scenario table, reset corner case and randomized
// sessions, all checked against a hold-length reference model of the checker.
module tb_nand_resp_checker;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned CNT_W  = 8;

    logic clk = 1'b0;
    logic rst, start, stop, a, b, y;
    logic             d_busy, d_done, d_pass, d_pulse;
    logic [CNT_W-1:0] d_chk, d_err;
    logic [3:0]       d_cov;
    logic [2:0]       d_fev;
    logic             s_busy, s_done, s_pass, s_pulse;
    logic [1:0]       s_chk, s_err;
    logic [3:0]       s_cov;
    logic [2:0]       s_fev;

    int total = 0;
    int bad   = 0;
    int pulses;
    int ymode;

    // Reference model: counts how many consecutive RUN cycles the pair has been held
    int         m_state;   // 0 idle, 1 run, 2 done
    int         m_chk, m_err, m_hold;
    logic [3:0] m_cov;
    logic [2:0] m_fev;
    logic [1:0] m_last;
    logic       m_pass, m_pulse;

    nand_resp_checker #(.SETTLE(SETTLE), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .a(a), .b(b), .y(y),
        .busy(d_busy), .done(d_done), .pass(d_pass), .chk_cnt(d_chk),
        .err_cnt(d_err), .cov(d_cov), .first_err_vec(d_fev), .err_pulse(d_pulse)
    );

    nand_resp_checker #(.SETTLE(SETTLE), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .a(a), .b(b), .y(y),
        .busy(s_busy), .done(s_done), .pass(s_pass), .chk_cnt(s_chk),
        .err_cnt(s_err), .cov(s_cov), .first_err_vec(s_fev), .err_pulse(s_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ymode;      // 0 good, 1 stuck-1, 2 stuck-0
        int         ntoggle;    // cycles of toggling a (b=0) before the segments
        int         nseg;
        logic [15:0] segs;      // segment k pair at [2k+1:2k]
        int         seg_len;
        int         exp_chk, exp_err;
        logic [3:0] exp_cov;
        logic       exp_pass;
        logic [2:0] exp_fev;
        int         exp_pulses;
        int         exp_sat_chk, exp_sat_err;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic y_for(input int mode, input logic ia, input logic ib);
        case (mode)
            1:       return 1'b1;
            2:       return 1'b0;
            3:       return ($urandom_range(0, 5) == 0) ? (ia & ib) : ~(ia & ib);
            default: return ~(ia & ib);
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_chk = 0; m_err = 0; m_hold = 0;
        m_cov = 4'h0; m_fev = 3'b000; m_last = 2'b00; m_pass = 1'b0; m_pulse = 1'b0;
    endtask

    task automatic model_step();
        logic [1:0] pr;
        logic       chk_now, mis;
        pr = {a, b};
        m_pulse = 1'b0;
        if (m_state != 1) begin
            if (start) begin
                m_state = 1; m_chk = 0; m_err = 0; m_cov = 4'h0;
                m_fev = 3'b000; m_pass = 1'b0; m_hold = 1;
            end
        end else begin
            m_hold  = (pr == m_last) ? m_hold + 1 : 1;
            chk_now = (m_hold == int'(SETTLE) + 1);
            if (chk_now) begin
                if (m_chk < 255) m_chk++;
                m_cov[pr] = 1'b1;
                mis = (y !== ~(a & b));
                if (mis) begin
                    if (m_err == 0) m_fev = {a, b, y};
                    if (m_err < 255) m_err++;
                    m_pulse = 1'b1;
                end
            end
            if (stop) begin
                m_state = 2;
                m_pass = (m_err == 0) && (m_cov == 4'hF) && (m_chk != 0);
            end
        end
        m_last = pr;
    endtask

    task automatic compare_model();
        check("busy",  32'(d_busy),  32'(m_state == 1));
        check("done",  32'(d_done),  32'(m_state == 2));
        check("pass",  32'(d_pass),  32'(m_pass));
        check("chk",   32'(d_chk),   32'(m_chk));
        check("err",   32'(d_err),   32'(m_err));
        check("cov",   32'(d_cov),   32'(m_cov));
        check("fev",   32'(d_fev),   32'(m_fev));
        check("pulse", 32'(d_pulse), 32'(m_pulse));
    endtask

    // One clock: model follows the sampled inputs, outputs compared 1ns later
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        #1;
        if (d_pulse) pulses++;
        compare_model();
    endtask

    task automatic drive(input logic ia, input logic ib);
        a = ia; b = ib; y = y_for(ymode, ia, ib);
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        logic [1:0] pr;
        ymode  = v.ymode;
        pulses = 0;
        start = 1'b1; drive(1'b0, 1'b0); tick();
        start = 1'b0;
        for (int i = 0; i < v.ntoggle; i++) begin
            drive(~i[0], 1'b0); tick();
        end
        for (int k = 0; k < v.nseg; k++) begin
            pr = v.segs[2*k +: 2];
            for (int j = 0; j < v.seg_len; j++) begin
                drive(pr[1], pr[0]); tick();
            end
        end
        stop = 1'b1; tick(); stop = 1'b0;
        check($sformatf("v%0d_chk", idx),    32'(d_chk),   32'(v.exp_chk));
        check($sformatf("v%0d_err", idx),    32'(d_err),   32'(v.exp_err));
        check($sformatf("v%0d_cov", idx),    32'(d_cov),   32'(v.exp_cov));
        check($sformatf("v%0d_pass", idx),   32'(d_pass),  32'(v.exp_pass));
        check($sformatf("v%0d_fev", idx),    32'(d_fev),   32'(v.exp_fev));
        check($sformatf("v%0d_done", idx),   32'(d_done),  32'd1);
        check($sformatf("v%0d_busy", idx),   32'(d_busy),  32'd0);
        check($sformatf("v%0d_pulses", idx), 32'(pulses),  32'(v.exp_pulses));
        check($sformatf("v%0d_sat_chk", idx), 32'(s_chk),  32'(v.exp_sat_chk));
        check($sformatf("v%0d_sat_err", idx), 32'(s_err),  32'(v.exp_sat_err));
        tick();
        check($sformatf("v%0d_hold_chk", idx), 32'(d_chk), 32'(v.exp_chk));
    endtask

    initial begin
        vecs[0] = '{0, 0, 4, 16'h00E4, 4, 4, 0, 4'hF, 1'b1, 3'b000, 0, 3, 0};
        vecs[1] = '{1, 0, 4, 16'h00E4, 4, 4, 1, 4'hF, 1'b0, 3'b111, 1, 3, 1};
        vecs[2] = '{0, 10, 1, 16'h0003, 4, 1, 0, 4'b1000, 1'b0, 3'b000, 0, 1, 0};
        vecs[3] = '{0, 0, 2, 16'h000C, 4, 2, 0, 4'b1001, 1'b0, 3'b000, 0, 2, 0};
        vecs[4] = '{2, 0, 5, 16'h0124, 4, 5, 5, 4'b0111, 1'b0, 3'b000, 5, 3, 3};

        rst = 1'b1; start = 1'b0; stop = 1'b0; ymode = 0; pulses = 0;
        drive(1'b0, 1'b0);
        model_reset();
        tick(); tick();
        rst = 1'b0;
        tick();
        check("reset_busy", 32'(d_busy), 32'd0);
        check("reset_chk",  32'(d_chk),  32'd0);

        // stop in IDLE is ignored
        stop = 1'b1; tick(); stop = 1'b0;
        check("idle_stop_done", 32'(d_done), 32'd0);

        for (int i = 0; i < 5; i++) apply_vec(vecs[i], i);

        // Asynchronous reset in the middle of a session
        ymode = 1;
        start = 1'b1; drive(1'b1, 1'b1); tick(); start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_err", 32'(d_err), 32'd1);
        rst = 1'b1;
        #1;
        check("arst_busy",  32'(d_busy),  32'd0);
        check("arst_done",  32'(d_done),  32'd0);
        check("arst_chk",   32'(d_chk),   32'd0);
        check("arst_err",   32'(d_err),   32'd0);
        check("arst_cov",   32'(d_cov),   32'd0);
        check("arst_fev",   32'(d_fev),   32'd0);
        check("arst_pass",  32'(d_pass),  32'd0);
        model_reset();
        tick();
        rst = 1'b0;
        tick();
        apply_vec(vecs[0], 5);

        // Randomized sessions with ignored start pulses and stop/start collisions
        for (int s = 0; s < 12; s++) begin
            int n, cyc, h;
            logic [1:0] pr;
            ymode = $urandom_range(0, 3);
            start = 1'b1; drive(1'($urandom), 1'($urandom)); tick(); start = 1'b0;
            n = $urandom_range(20, 60);
            cyc = 0;
            while (cyc < n) begin
                pr = 2'($urandom);
                h  = $urandom_range(1, 5);
                for (int j = 0; j < h; j++) begin
                    start = ($urandom_range(0, 9) == 0);
                    drive(pr[1], pr[0]); tick();
                    cyc++;
                end
            end
            stop = 1'b1; start = 1'($urandom); drive(a, b); tick();
            stop = 1'b0; start = 1'b0;
            for (int j = 0; j < 3; j++) begin
                stop = 1'($urandom);
                drive(1'($urandom), 1'($urandom)); tick();
            end
            stop = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
